// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle ARM core: sequences fetch/decode/execute/memory/writeback,
// holds the NZCV flags and gates every architectural write with the condition check.
module multicycle_controller #(
    parameter logic [3:0] PC_IDX  = 4'd15,
    parameter int         STATE_W = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [3:0]         Cond,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic [3:0]         ALUFlags,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUControl,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic [STATE_W-1:0] StateOut
);

    typedef enum logic [STATE_W-1:0] {
        FETCH  = STATE_W'(0),
        DECODE = STATE_W'(1),
        MEMADR = STATE_W'(2),
        MEMRD  = STATE_W'(3),
        MEMWB  = STATE_W'(4),
        MEMWR  = STATE_W'(5),
        EXECR  = STATE_W'(6),
        EXECI  = STATE_W'(7),
        ALUWB  = STATE_W'(8),
        BRANCH = STATE_W'(9)
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] flags_reg, flags_next;
    logic       cond_ex;
    logic [1:0] dp_alu;
    logic       dp_is_cmp;
    logic       pc_write, ir_write, reg_write, mem_write;

    wire        flag_n = flags_reg[3];
    wire        flag_z = flags_reg[2];
    wire        flag_c = flags_reg[1];
    wire        flag_v = flags_reg[0];
    wire [3:0]  cmd    = Funct[4:1];
    wire        rd_is_pc = (Rd == PC_IDX);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= FETCH;
            flags_reg <= 4'b0000;
        end else begin
            state_reg <= state_next;
            flags_reg <= flags_next;
        end
    end

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Data-processing command decode; unsupported commands fall back to ADD.
    always_comb begin
        dp_alu    = 2'b00;
        dp_is_cmp = 1'b0;
        case (cmd)
            4'b0100: dp_alu = 2'b00;
            4'b0010: dp_alu = 2'b01;
            4'b0000: dp_alu = 2'b10;
            4'b1100: dp_alu = 2'b11;
            4'b1010: begin
                dp_alu    = 2'b01;
                dp_is_cmp = 1'b1;
            end
            default: dp_alu = 2'b00;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        flags_next = flags_reg;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        ResultSrc  = 2'b00;
        case (state_reg)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_write  = MemReady;
                ir_write  = MemReady;
                if (MemReady) state_next = DECODE;
            end
            DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (!cond_ex) begin
                    state_next = FETCH;
                end else begin
                    case (Op)
                        2'b00:   state_next = Funct[5] ? EXECI : EXECR;
                        2'b01:   state_next = MEMADR;
                        2'b10:   state_next = BRANCH;
                        default: state_next = FETCH;
                    endcase
                end
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state_reg == EXECI) ? 2'b01 : 2'b00;
                ALUControl = dp_alu;
                // Logical ops leave C and V untouched.
                if (Funct[0] || dp_is_cmp) begin
                    flags_next[3:2] = ALUFlags[3:2];
                    if (!dp_alu[1]) flags_next[1:0] = ALUFlags[1:0];
                end
                state_next = dp_is_cmp ? FETCH : ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                pc_write   = rd_is_pc;
                state_next = FETCH;
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = Funct[3] ? 2'b00 : 2'b01;
                state_next = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                reg_write  = 1'b1;
                pc_write   = rd_is_pc;
                state_next = FETCH;
            end
            MEMWR: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                if (MemReady) state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                pc_write   = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // Reset asynchronously kills every architectural write, even mid-access.
    assign PCWrite  = pc_write  & RST_N;
    assign IRWrite  = ir_write  & RST_N;
    assign RegWrite = reg_write & RST_N;
    assign MemWrite = mem_write & RST_N;

    assign ImmSrc   = Op;
    assign RegSrc   = {(Op == 2'b01), (Op == 2'b10)};
    assign StateOut = state_reg;

endmodule
